rv32i_fetch_unit: RTL and testbench
===================================

Name: rv32i_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the instruction memory.
- Owns the PC and drives the memory address port; the memory returns the instruction word combinationally in the same cycle.
- Buffers {pc, instr} pairs in a small queue and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the queue.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, fetch queue entries (power of two, minimum 2).
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned redirect (used only when the optional feature is enabled).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals PC.
- imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_pc  input  32  redirect target byte address.
- id_valid  output  1  head queue entry is valid.
- id_ready  input  1  decode accepts the head entry this cycle.
- id_instr  output  32  head instruction.
- id_pc  output  32  PC of the head instruction.
- q_count  output  $clog2(DEPTH)+1  current queue occupancy.
- misalign_fault  output  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (asynchronous, any cycle including mid-fetch or mid-redirect):
  - PC = RESET_PC, queue empty, q_count = 0.
  - id_valid = 0, id_instr = 32'h0000_0013 (NOP), id_pc = 0, misalign_fault = 0.
  - The first push occurs on the first rising edge after reset deasserts.
- imem_addr = PC (combinational).
- pop = id_valid && id_ready.
- push = !redirect_valid && (q_count < DEPTH || pop).
  - On push: enqueue {PC, imem_rdata}; PC <= PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - When the queue is full and there is no pop, PC holds and imem_addr is stable.
- Simultaneous push and pop when full: both occur, occupancy unchanged.
- Simultaneous push and pop when empty: forbidden by construction, since id_valid = 0.
- Redirect has highest priority:
  - Queue flushed (q_count <= 0) and PC <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle; any pop that cycle is ignored (the head is discarded, not consumed).
  - Timing: redirect at cycle N -> imem_addr = target at N+1 -> id_valid = 1 with the target instruction at N+2.
  - Back-to-back redirects: the last one wins; id_valid stays 0 until two cycles after the final redirect.
- Outputs are driven from the head entry register (no combinational path from imem_rdata to id_*).
  - When empty: id_valid = 0, id_instr = NOP, id_pc = last head PC.
- Ordering: strictly in PC order; no entry is duplicated or dropped except by flush.
- Queue implementation: circular buffer with read/write pointers and a count.
  - Pointers wrap at DEPTH.
  - Count never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 still flushes the queue.
  - PC <= TRAP_VEC instead of the target.
  - misalign_fault is set and stays set until reset.
- Undefined:
  - Low two bits of redirect_pc are silently cleared.
  - misalign_fault is tied to 0.

Decomposition:
- Package rv32i_pkg:
  - XLEN = 32.
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - Typedef fetch_entry_t = {pc[31:0], instr[31:0]}.
- One natural sub-module: rv32i_fetch_queue.
  - Parameterised circular buffer with push/pop/flush, count, and head outputs.
  - The top level holds the PC register, next-PC logic and the misalign check.

Test Plan:
1. Reset release, id_ready = 1, memory words 0..7 = 32'h1000_0000 + index -> from cycle 2 after reset, one entry per cycle; id_pc = 0, 4, 8...; id_instr matches the word index.
2. id_ready = 0 for 5 cycles -> q_count saturates at 2 and imem_addr holds at 8; on id_ready = 1, entries at PC 0 and 4 drain in order with no loss or duplication.
3. redirect_valid = 1, redirect_pc = 32'h20 while the queue is full and id_ready = 1 -> next cycle q_count = 0 and imem_addr = 32'h20; id_valid = 1 with id_pc = 32'h20 two cycles after the redirect.
4. Redirect to 32'h22 -> without the macro: PC = 32'h20, misalign_fault = 0; with FETCH_MISALIGN_CHECK_EN: PC = 32'h100 and misalign_fault = 1 until reset.
5. Assert reset mid-stream with q_count = 2 -> id_valid = 0 immediately (asynchronous), imem_addr = RESET_PC; refetch restarts at 0 after release.
6. PC = 32'hFFFF_FFFC via redirect -> next push wraps PC to 0; entries appear with id_pc = FFFF_FFFC then 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the rv32i fetch slice
package rv32i_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_queue.sv
// rtl/rv32i_fetch_queue.sv - circular {pc, instr} buffer with push/pop/flush and registered head
module rv32i_fetch_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output logic                   head_valid,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] last_pc;
  logic            do_push;
  logic            do_pop;

  assign head_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign do_pop     = pop && head_valid && !flush;
  assign do_push    = push && !flush && (!full || do_pop);

  // Once empty, the head PC keeps showing the last entry that sat at the head.
  assign head.pc    = head_valid ? mem[rd_ptr].pc    : last_pc;
  assign head.instr = head_valid ? mem[rd_ptr].instr : NOP_INSTR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      last_pc <= '0;
    end else begin
      if (head_valid) begin
        last_pc <= mem[rd_ptr].pc;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rtl/rv32i_fetch_unit.sv - PC owner and fetch queue front end; optional FETCH_MISALIGN_CHECK_EN traps misaligned redirects
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   misalign_fault
);

  logic [31:0]  pc;
  logic [31:0]  redirect_target;
  logic         take_trap;
  logic         pop;
  logic         push;
  logic         full;
  fetch_entry_t wentry;
  fetch_entry_t head;

  assign imem_addr = pc;
  assign pop       = id_valid && id_ready;
  assign push      = !redirect_valid && (!full || pop);
  assign wentry    = '{pc: pc, instr: imem_rdata};
  assign id_pc     = head.pc;
  assign id_instr  = head.instr;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign take_trap = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_fault <= 1'b0;
    end else if (take_trap) begin
      misalign_fault <= 1'b1;
    end
  end
`else
  assign take_trap      = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  assign redirect_target = take_trap ? TRAP_VEC : (redirect_pc & ~32'h3);

  // Redirect outranks fetch progress; a full queue without a pop stalls the PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  rv32i_fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .wdata     (wentry),
    .head_valid(id_valid),
    .head      (head),
    .count     (q_count),
    .full      (full)
  );

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb/tb_rv32i_fetch_unit.sv - directed self-checking bench for rv32i_fetch_unit
module tb_rv32i_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [1:0]  q_count;
  logic        misalign_fault;

  int vectors = 0;
  int miscompares = 0;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] EXP_MIS_PC    = 32'h0000_0100;
  localparam logic        EXP_MIS_FAULT = 1'b1;
`else
  localparam logic [31:0] EXP_MIS_PC    = 32'h0000_0020;
  localparam logic        EXP_MIS_FAULT = 1'b0;
`endif

  rv32i_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .q_count       (q_count),
    .misalign_fault(misalign_fault)
  );

  // Memory word at byte address a holds 32'h1000_0000 + (a >> 2).
  assign imem_rdata = 32'h1000_0000 + (imem_addr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    vectors++; if (id_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_id_instr: got %h expected 00000013", id_instr); end
    vectors++; if (id_pc !== 32'h0) begin miscompares++; $display("FAIL reset_id_pc: got %h expected 00000000", id_pc); end
    vectors++; if (q_count !== 2'd0) begin miscompares++; $display("FAIL reset_q_count: got %0d expected 0", q_count); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_imem_addr: got %h expected 00000000", imem_addr); end
    vectors++; if (misalign_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b expected 0", misalign_fault); end
  endtask

  task automatic test_stream();
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, id_valid); end
      vectors++; if (id_pc !== 32'(4 * i)) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, id_pc, 32'(4 * i)); end
      vectors++; if (id_instr !== 32'h1000_0000 + 32'(i)) begin miscompares++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, id_instr, 32'h1000_0000 + 32'(i)); end
      vectors++; if (q_count !== 2'd1) begin miscompares++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, q_count); end
    end
    vectors++; if (imem_addr !== 32'h20) begin miscompares++; $display("FAIL stream_addr_end: got %h expected 00000020", imem_addr); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    vectors++; if (q_count !== 2'd2) begin miscompares++; $display("FAIL stall_count: got %0d expected 2", q_count); end
    vectors++; if (imem_addr !== 32'h8) begin miscompares++; $display("FAIL stall_addr: got %h expected 00000008", imem_addr); end
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (id_pc !== exp_pc[i] || id_instr !== 32'h1000_0000 + 32'(i)) begin miscompares++; $display("FAIL drain[%0d]: got pc %h instr %h expected pc %h instr %h", i, id_pc, id_instr, exp_pc[i], 32'h1000_0000 + 32'(i)); end
      vectors++; if (q_count !== 2'd2) begin miscompares++; $display("FAIL drain_count[%0d]: got %0d expected 2", i, q_count); end
      step();
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    vectors++; if (q_count !== 2'd0) begin miscompares++; $display("FAIL redir_count: got %0d expected 0", q_count); end
    vectors++; if (imem_addr !== 32'h20) begin miscompares++; $display("FAIL redir_addr: got %h expected 00000020", imem_addr); end
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid_n1: got %b expected 0", id_valid); end
    step();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_instr !== 32'h1000_0008) begin miscompares++; $display("FAIL redir_head: got v%b pc %h instr %h expected v1 pc 00000020 instr 10000008", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    vectors++; if (imem_addr !== 32'h40 || id_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_first: got addr %h v%b expected addr 00000040 v0", imem_addr, id_valid); end
    redirect_pc = 32'h60;
    step();
    redirect_valid = 1'b0;
    vectors++; if (imem_addr !== 32'h60 || id_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_second: got addr %h v%b expected addr 00000060 v0", imem_addr, id_valid); end
    step();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h60) begin miscompares++; $display("FAIL b2b_head: got v%b pc %h expected v1 pc 00000060", id_valid, id_pc); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    step();
    vectors++; if (imem_addr !== EXP_MIS_PC) begin miscompares++; $display("FAIL misalign_pc: got %h expected %h", imem_addr, EXP_MIS_PC); end
    vectors++; if (misalign_fault !== EXP_MIS_FAULT) begin miscompares++; $display("FAIL misalign_fault: got %b expected %b", misalign_fault, EXP_MIS_FAULT); end
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    vectors++; if (imem_addr !== 32'h40 || misalign_fault !== EXP_MIS_FAULT) begin miscompares++; $display("FAIL misalign_sticky: got addr %h fault %b expected addr 00000040 fault %b", imem_addr, misalign_fault, EXP_MIS_FAULT); end
    step();
    vectors++; if (misalign_fault !== EXP_MIS_FAULT) begin miscompares++; $display("FAIL misalign_hold: got %b expected %b", misalign_fault, EXP_MIS_FAULT); end
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    step(); step(); step();
    vectors++; if (q_count !== 2'd2) begin miscompares++; $display("FAIL midrst_pre_count: got %0d expected 2", q_count); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (id_valid !== 1'b0 || q_count !== 2'd0) begin miscompares++; $display("FAIL midrst_async: got v%b count %0d expected v0 count 0", id_valid, q_count); end
    vectors++; if (imem_addr !== 32'h0 || misalign_fault !== 1'b0) begin miscompares++; $display("FAIL midrst_pc_fault: got addr %h fault %b expected addr 00000000 fault 0", imem_addr, misalign_fault); end
    step();
    reset = 1'b0;
    id_ready = 1'b1;
    step();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h1000_0000) begin miscompares++; $display("FAIL midrst_refetch: got v%b pc %h instr %h expected v1 pc 00000000 instr 10000000", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
    step();
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_pc_zero: got %h expected 00000000", imem_addr); end
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'h4FFF_FFFF) begin miscompares++; $display("FAIL wrap_head0: got v%b pc %h instr %h expected v1 pc fffffffc instr 4fffffff", id_valid, id_pc, id_instr); end
    step();
    vectors++; if (id_pc !== 32'h0 || id_instr !== 32'h1000_0000 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL wrap_head1: got pc %h instr %h addr %h expected pc 00000000 instr 10000000 addr 00000004", id_pc, id_instr, imem_addr); end
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
